// File: rtl/cache_ctrl_pkg.sv
// Shared types and encodings for the two-way cache controller.
// State enum, write-select encodings, physical-address mux encodings,
// and a saturating increment helper used by the optional event counters.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CHECK     = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_FILL      = 2'd3
    } state_e;

    // Per-way data array write enables
    localparam logic [1:0] WSEL_NONE = 2'b00;
    localparam logic [1:0] WSEL_ALL  = 2'b01;  // whole line from physical memory
    localparam logic [1:0] WSEL_MASK = 2'b11;  // byte-masked CPU write

    // Physical memory address source (dirty_write)
    localparam logic [1:0] PADDR_CPU  = 2'b00;
    localparam logic [1:0] PADDR_WAY1 = 2'b01;
    localparam logic [1:0] PADDR_WAY2 = 2'b11;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// Saturating hit / miss / writeback event counters for cache_control.
// Instantiated only when CACHE_PERF_COUNTERS_EN is defined.
module cache_perf_cnt
    import cache_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        hit_ev,
    input  logic        miss_ev,
    input  logic        wb_ev,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count
);

    logic [31:0] hit_q, hit_d;
    logic [31:0] miss_q, miss_d;
    logic [31:0] wb_q, wb_d;

    // Next counter values: bump on each event, hold at saturation
    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        wb_d   = wb_q;
        if (hit_ev)  hit_d  = sat_inc(hit_q);
        if (miss_ev) miss_d = sat_inc(miss_q);
        if (wb_ev)   wb_d   = sat_inc(wb_q);
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q  <= '0;
            miss_q <= '0;
            wb_q   <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
            wb_q   <= wb_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for a two-way set-associative, write-back cache.
// IDLE -> CHECK on a request; a hit answers in CHECK, a miss goes through
// an optional WRITEBACK of a dirty victim and then FILL, returning to CHECK
// where the request hits. lru_out names the victim (0 = way1, 1 = way2).
// Optional build macro: CACHE_PERF_COUNTERS_EN adds hit/miss/writeback counters.
//
// Handshakes: mem_read/mem_write are held by the CPU until the one-cycle
// mem_resp pulse; pmem_read/pmem_write are held by this block until the
// cycle in which pmem_resp is high, which completes the transfer. pmem_resp
// outside WRITEBACK/FILL carries no meaning and is ignored.
module cache_control
    import cache_ctrl_pkg::*;
#(
    parameter int s_tag   = 24,
    parameter int s_index = 3
) (
    input  logic             clk,
    input  logic             rst,            // asynchronous, active-low
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic [s_tag-1:0] addr_tag,
    input  logic [s_tag-1:0] tag1_mem,
    input  logic [s_tag-1:0] tag2_mem,
    input  logic             valid1_out,
    input  logic             valid2_out,
    input  logic             dirty1_out,
    input  logic             dirty2_out,
    input  logic             lru_out,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    output logic             tag1_ld,
    output logic             tag2_ld,
    output logic             valid1_ld,
    output logic             valid2_ld,
    output logic             dirty1_ld,
    output logic             dirty2_ld,
    output logic             lru_ld,
    output logic             valid1_in,
    output logic             valid2_in,
    output logic             dirty1_in,
    output logic             dirty2_in,
    output logic             lru_in,
    output logic [1:0]       write1_select,
    output logic [1:0]       write2_select,
    output logic [1:0]       dirty_write,
    output logic             bus_select1,
    output logic             bus_select2,
    output logic             cache_out_select,
`ifdef CACHE_PERF_COUNTERS_EN
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count,
    output logic [31:0]      wb_count,
`endif
    output state_e           state_dbg
);

    // The set index is decoded in the datapath; only guard its range here.
    if (s_index < 1 || s_index > 16) begin : g_bad_index
        $error("cache_control: s_index out of range");
    end

    state_e state_q, state_d;
    logic   victim_q, victim_d;   // way chosen at miss time: 0 = way1, 1 = way2
    logic   hit1, hit2, hit;

    // Way1 has priority when both ways match
    assign hit1 = valid1_out && (tag1_mem == addr_tag);
    assign hit2 = valid2_out && (tag2_mem == addr_tag) && !hit1;
    assign hit  = hit1 || hit2;

    // Next state and all datapath controls from the current state
    always_comb begin
        state_d          = state_q;
        victim_d         = victim_q;
        mem_resp         = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        tag1_ld          = 1'b0;
        tag2_ld          = 1'b0;
        valid1_ld        = 1'b0;
        valid2_ld        = 1'b0;
        dirty1_ld        = 1'b0;
        dirty2_ld        = 1'b0;
        lru_ld           = 1'b0;
        valid1_in        = 1'b0;
        valid2_in        = 1'b0;
        dirty1_in        = 1'b0;
        dirty2_in        = 1'b0;
        lru_in           = 1'b0;
        write1_select    = WSEL_NONE;
        write2_select    = WSEL_NONE;
        dirty_write      = PADDR_CPU;
        bus_select1      = 1'b0;
        bus_select2      = 1'b0;
        cache_out_select = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) state_d = ST_CHECK;
            end

            ST_CHECK: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    lru_ld   = 1'b1;
                    lru_in   = hit1;       // way1 just used -> way2 is next victim
                    state_d  = ST_IDLE;
                    // A write (including read+write) merges CPU data into the hit way
                    if (mem_write) begin
                        if (hit1) begin
                            write1_select = WSEL_MASK;
                            bus_select1   = 1'b1;
                            dirty1_ld     = 1'b1;
                            dirty1_in     = 1'b1;
                        end else begin
                            write2_select = WSEL_MASK;
                            bus_select2   = 1'b1;
                            dirty2_ld     = 1'b1;
                            dirty2_in     = 1'b1;
                        end
                    end
                end else begin
                    victim_d = lru_out;
                    if (lru_out ? (valid2_out && dirty2_out) : (valid1_out && dirty1_out))
                        state_d = ST_WRITEBACK;
                    else
                        state_d = ST_FILL;
                end
            end

            ST_WRITEBACK: begin
                pmem_write       = 1'b1;
                dirty_write      = victim_q ? PADDR_WAY2 : PADDR_WAY1;
                cache_out_select = victim_q;
                if (pmem_resp) state_d = ST_FILL;
            end

            ST_FILL: begin
                pmem_read   = 1'b1;
                dirty_write = PADDR_CPU;
                // bus_select for the victim stays 0: data comes from memory
                if (pmem_resp) begin
                    if (!victim_q) begin
                        write1_select = WSEL_ALL;
                        tag1_ld       = 1'b1;
                        valid1_ld     = 1'b1;
                        valid1_in     = 1'b1;
                        dirty1_ld     = 1'b1;
                        dirty1_in     = 1'b0;
                    end else begin
                        write2_select = WSEL_ALL;
                        tag2_ld       = 1'b1;
                        valid2_ld     = 1'b1;
                        valid2_in     = 1'b1;
                        dirty2_ld     = 1'b1;
                        dirty2_in     = 1'b0;
                    end
                    state_d = ST_CHECK;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and victim registers; reset abandons any memory transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    assign state_dbg = state_q;

`ifdef CACHE_PERF_COUNTERS_EN
    logic hit_ev, miss_ev, wb_ev;
    assign hit_ev  = (state_q == ST_CHECK) && hit;
    assign miss_ev = (state_q == ST_CHECK) && !hit;
    assign wb_ev   = (state_q == ST_WRITEBACK) && pmem_resp;

    cache_perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .hit_ev     (hit_ev),
        .miss_ev    (miss_ev),
        .wb_ev      (wb_ev),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );
`endif

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control. The bench plays the tag/status datapath from a
// per-set array model and predicts, per request, the cycle-by-cycle control
// outputs (hit, clean miss, dirty miss) from the cache protocol rules.
module tb_cache_control;
    import cache_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        mem_read, mem_write, mem_resp;
    logic [23:0] addr_tag, tag1_mem, tag2_mem;
    logic        valid1_out, valid2_out, dirty1_out, dirty2_out, lru_out;
    logic        pmem_read, pmem_write, pmem_resp;
    logic        tag1_ld, tag2_ld, valid1_ld, valid2_ld, dirty1_ld, dirty2_ld, lru_ld;
    logic        valid1_in, valid2_in, dirty1_in, dirty2_in, lru_in;
    logic [1:0]  write1_select, write2_select, dirty_write;
    logic        bus_select1, bus_select2, cache_out_select;
    state_e      state_dbg;
`ifdef CACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    cache_control #(.s_tag(24), .s_index(3)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .addr_tag(addr_tag), .tag1_mem(tag1_mem), .tag2_mem(tag2_mem),
        .valid1_out(valid1_out), .valid2_out(valid2_out),
        .dirty1_out(dirty1_out), .dirty2_out(dirty2_out), .lru_out(lru_out),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .tag1_ld(tag1_ld), .tag2_ld(tag2_ld), .valid1_ld(valid1_ld), .valid2_ld(valid2_ld),
        .dirty1_ld(dirty1_ld), .dirty2_ld(dirty2_ld), .lru_ld(lru_ld),
        .valid1_in(valid1_in), .valid2_in(valid2_in), .dirty1_in(dirty1_in),
        .dirty2_in(dirty2_in), .lru_in(lru_in),
        .write1_select(write1_select), .write2_select(write2_select),
        .dirty_write(dirty_write), .bus_select1(bus_select1), .bus_select2(bus_select2),
        .cache_out_select(cache_out_select),
`ifdef CACHE_PERF_COUNTERS_EN
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- output bundle ----------------
    typedef struct packed {
        logic       mem_resp, pmem_read, pmem_write;
        logic       tag1_ld, tag2_ld, valid1_ld, valid2_ld, dirty1_ld, dirty2_ld, lru_ld;
        logic       valid1_in, valid2_in, dirty1_in, dirty2_in, lru_in;
        logic [1:0] write1_select, write2_select, dirty_write;
        logic       bus_select1, bus_select2, cache_out_select;
    } out_t;

    out_t dut_o;
    assign dut_o = {mem_resp, pmem_read, pmem_write,
                    tag1_ld, tag2_ld, valid1_ld, valid2_ld, dirty1_ld, dirty2_ld, lru_ld,
                    valid1_in, valid2_in, dirty1_in, dirty2_in, lru_in,
                    write1_select, write2_select, dirty_write,
                    bus_select1, bus_select2, cache_out_select};

    // ---------------- model state ----------------
    logic [23:0] m_tag   [8][2];
    logic        m_valid [8][2];
    logic        m_dirty [8][2];
    logic        m_lru   [8];
    int          cur_set;
    logic [31:0] m_hit, m_miss, m_wb;

    out_t        exp_q [$];
    out_t        msk_q [$];
    logic [31:0] exph_q[$], expm_q[$], expw_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int req_cyc  = 0;
    int last_lat = 0;

    // Strobes, loads, selects and dirty_write always checked; data-in and
    // mux selects only where they matter.
    function automatic out_t base_mask();
        out_t m;
        m = '1;
        m.valid1_in = 1'b0; m.valid2_in = 1'b0;
        m.dirty1_in = 1'b0; m.dirty2_in = 1'b0; m.lru_in = 1'b0;
        m.bus_select1 = 1'b0; m.bus_select2 = 1'b0; m.cache_out_select = 1'b0;
        return m;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_status();
        tag1_mem   = m_tag[cur_set][0];
        tag2_mem   = m_tag[cur_set][1];
        valid1_out = m_valid[cur_set][0];
        valid2_out = m_valid[cur_set][1];
        dirty1_out = m_dirty[cur_set][0];
        dirty2_out = m_dirty[cur_set][1];
        lru_out    = m_lru[cur_set];
    endtask

    // Queue this cycle's expectation, account events, advance one cycle
    task automatic step(input out_t e, input out_t m, input logic ev_h, input logic ev_m,
                        input logic ev_w);
        exp_q.push_back(e);
        msk_q.push_back(m);
        exph_q.push_back(m_hit);
        expm_q.push_back(m_miss);
        expw_q.push_back(m_wb);
        if (ev_h && m_hit  != 32'hFFFF_FFFF) m_hit  = m_hit + 1;
        if (ev_m && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
        if (ev_w && m_wb   != 32'hFFFF_FFFF) m_wb   = m_wb + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, got, want);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            pmem_resp = 1'($urandom_range(0, 1));
            drive_status();
            step('0, base_mask(), 1'b0, 1'b0, 1'b0);
        end
        pmem_resp = 1'b0;
    endtask

    task automatic exp_hit(input logic w, input logic wr, output out_t e, output out_t m);
        e = '0; m = base_mask();
        e.mem_resp = 1'b1; e.lru_ld = 1'b1; e.lru_in = (w == 1'b0); m.lru_in = 1'b1;
        if (wr) begin
            if (w == 1'b0) begin
                e.write1_select = 2'b11; e.bus_select1 = 1'b1; e.dirty1_ld = 1'b1; e.dirty1_in = 1'b1;
                m.bus_select1 = 1'b1; m.dirty1_in = 1'b1;
            end else begin
                e.write2_select = 2'b11; e.bus_select2 = 1'b1; e.dirty2_ld = 1'b1; e.dirty2_in = 1'b1;
                m.bus_select2 = 1'b1; m.dirty2_in = 1'b1;
            end
        end
    endtask

    task automatic exp_wb(input logic v, output out_t e, output out_t m);
        e = '0; m = base_mask();
        e.pmem_write = 1'b1;
        e.dirty_write = v ? 2'b11 : 2'b01;
        e.cache_out_select = v; m.cache_out_select = 1'b1;
    endtask

    task automatic exp_fill(input logic v, input logic last, output out_t e, output out_t m);
        e = '0; m = base_mask();
        e.pmem_read = 1'b1;
        if (v == 1'b0) begin
            m.bus_select1 = 1'b1;
            if (last) begin
                e.write1_select = 2'b01; e.tag1_ld = 1'b1; e.valid1_ld = 1'b1; e.valid1_in = 1'b1;
                e.dirty1_ld = 1'b1; m.valid1_in = 1'b1; m.dirty1_in = 1'b1;
            end
        end else begin
            m.bus_select2 = 1'b1;
            if (last) begin
                e.write2_select = 2'b01; e.tag2_ld = 1'b1; e.valid2_ld = 1'b1; e.valid2_in = 1'b1;
                e.dirty2_ld = 1'b1; m.valid2_in = 1'b1; m.dirty2_in = 1'b1;
            end
        end
    endtask

    // One complete CPU request: predicted from the set model, then applied to it
    task automatic do_req(input int set, input logic [23:0] tag, input logic rd, input logic wr,
                          input int wb_wait, input int fill_wait);
        out_t e, m;
        logic h1, h2, v;
        cur_set   = set;
        addr_tag  = tag;
        mem_read  = rd;
        mem_write = wr;
        drive_status();
        pmem_resp = 1'($urandom_range(0, 1));
        step('0, base_mask(), 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            drive_status();
            pmem_resp = 1'($urandom_range(0, 1));
            h1 = m_valid[set][0] && (m_tag[set][0] == tag);
            h2 = m_valid[set][1] && (m_tag[set][1] == tag);
            if (h1 || h2) begin
                v = h1 ? 1'b0 : 1'b1;
                exp_hit(v, wr, e, m);
                step(e, m, 1'b1, 1'b0, 1'b0);
                m_lru[set] = (v == 1'b0);
                if (wr) m_dirty[set][v] = 1'b1;
                break;
            end
            v = m_lru[set];
            step('0, base_mask(), 1'b0, 1'b1, 1'b0);
            if (m_valid[set][v] && m_dirty[set][v]) begin
                for (int i = 0; i < wb_wait; i++) begin
                    pmem_resp = (i == wb_wait - 1);
                    exp_wb(v, e, m);
                    step(e, m, 1'b0, 1'b0, i == wb_wait - 1);
                end
            end
            for (int i = 0; i < fill_wait; i++) begin
                pmem_resp = (i == fill_wait - 1);
                exp_fill(v, i == fill_wait - 1, e, m);
                step(e, m, 1'b0, 1'b0, 1'b0);
            end
            m_tag[set][v]   = tag;
            m_valid[set][v] = 1'b1;
            m_dirty[set][v] = 1'b0;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
    endtask

    // ---------------- scoreboard: compare every cycle ----------------
    always @(negedge clk) begin
        out_t e, m;
        logic [31:0] eh, em, ew;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            m  = msk_q.pop_front();
            eh = exph_q.pop_front();
            em = expm_q.pop_front();
            ew = expw_q.pop_front();
            n_checks++;
            if (((dut_o ^ e) & m) === '0) n_pass++;
            else $display("FAIL outputs @%0t: got %h want %h (mask %h)", $time, dut_o, e, m);
`ifdef CACHE_PERF_COUNTERS_EN
            n_checks++;
            if ({hit_count, miss_count, wb_count} === {eh, em, ew}) n_pass++;
            else $display("FAIL counters @%0t: got %0d/%0d/%0d want %0d/%0d/%0d", $time,
                          hit_count, miss_count, wb_count, eh, em, ew);
`endif
        end
        // request-to-response latency in cycles, counting both end cycles
        if (rst && (mem_read || mem_write)) req_cyc = req_cyc + 1;
        if (mem_resp) begin
            last_lat = req_cyc;
            req_cyc  = 0;
        end else if (!(mem_read || mem_write)) begin
            req_cyc = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        out_t e, m;
        logic [23:0] tag;
        int set, op;

        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        addr_tag = '0; cur_set = 0;
        m_hit = '0; m_miss = '0; m_wb = '0;
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_tag[s][w]   = 24'($urandom);
                m_valid[s][w] = 1'($urandom_range(0, 1));
                m_dirty[s][w] = 1'($urandom_range(0, 1));
            end
            m_lru[s] = 1'($urandom_range(0, 1));
        end
        drive_status();

        // reset state
        @(posedge clk); #1;
        step('0, '1, 1'b0, 1'b0, 1'b0);
        check("reset state idle", 32'(state_dbg), 32'(ST_IDLE));
        step('0, '1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle_cycles(2);

        // read hit in way1
        m_tag[0][0] = 24'h000123; m_valid[0][0] = 1'b1; m_dirty[0][0] = 1'b0;
        m_tag[0][1] = 24'h000456; m_valid[0][1] = 1'b0;
        do_req(0, 24'h000123, 1'b1, 1'b0, 1, 1);
        check("read hit latency", last_lat, 2);
        check("read hit lru model", 32'(m_lru[0]), 1);

        // write hit in way2
        m_tag[1][0] = 24'h010101; m_valid[1][0] = 1'b1;
        m_tag[1][1] = 24'hABCDEF; m_valid[1][1] = 1'b1; m_dirty[1][1] = 1'b0;
        do_req(1, 24'hABCDEF, 1'b0, 1'b1, 1, 1);
        check("write hit latency", last_lat, 2);
        check("write hit dirty model", 32'(m_dirty[1][1]), 1);

        // clean miss into way1, five-cycle fill
        m_tag[2][0] = 24'h222222; m_valid[2][0] = 1'b1; m_dirty[2][0] = 1'b0;
        m_tag[2][1] = 24'h333333; m_valid[2][1] = 1'b1; m_lru[2] = 1'b0;
        do_req(2, 24'h000999, 1'b1, 1'b0, 1, 5);
        check("clean miss latency", last_lat, 8);

        // dirty miss on way2: 3-cycle writeback, 4-cycle fill
        m_tag[3][0] = 24'h454545; m_valid[3][0] = 1'b1;
        m_tag[3][1] = 24'h444444; m_valid[3][1] = 1'b1; m_dirty[3][1] = 1'b1; m_lru[3] = 1'b1;
        do_req(3, 24'h0ABCDE, 1'b1, 1'b0, 3, 4);
        check("dirty miss latency", last_lat, 10);

        // both ways match: way1 wins; read+write counts as write
        m_tag[4][0] = 24'h777000; m_valid[4][0] = 1'b1;
        m_tag[4][1] = 24'h777000; m_valid[4][1] = 1'b1;
        do_req(4, 24'h777000, 1'b1, 1'b1, 1, 1);
        check("dual hit way1 dirty", 32'(m_dirty[4][0]), 1);
        idle_cycles(1);

        // reset in the middle of a writeback
        m_tag[5][0] = 24'h111111; m_valid[5][0] = 1'b1; m_dirty[5][0] = 1'b0;
        m_tag[5][1] = 24'h55AA55; m_valid[5][1] = 1'b1; m_dirty[5][1] = 1'b1; m_lru[5] = 1'b1;
        cur_set = 5; addr_tag = 24'h777777; mem_read = 1'b1; drive_status();
        step('0, base_mask(), 1'b0, 1'b0, 1'b0);
        step('0, base_mask(), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_wb(1'b1, e, m);
            step(e, m, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0; mem_read = 1'b0;
        m_hit = '0; m_miss = '0; m_wb = '0;
        step('0, '1, 1'b0, 1'b0, 1'b0);
        step('0, '1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle_cycles(1);

        // after reset: three hits then one dirty miss
        do_req(5, 24'h111111, 1'b1, 1'b0, 1, 1);
        do_req(5, 24'h111111, 1'b0, 1'b1, 1, 1);
        do_req(5, 24'h111111, 1'b1, 1'b0, 1, 1);
        do_req(5, 24'h777777, 1'b1, 1'b0, 3, 2);
        check("post-reset dirty miss latency", last_lat, 8);
`ifdef CACHE_PERF_COUNTERS_EN
        check("hit_count literal", hit_count, 4);
        check("miss_count literal", miss_count, 1);
        check("wb_count literal", wb_count, 1);
`endif

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            set = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) tag = m_tag[set][$urandom_range(0, 1)];
            else tag = 24'($urandom);
            op = $urandom_range(0, 2);
            do_req(set, tag, op != 1, op != 0, $urandom_range(1, 4), $urandom_range(1, 4));
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(2);
        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
